// File: rtl/sram_march_bist_if.sv
`default_nettype none
// =============================================================================
// sram_march_bist_if : SRAM BIST-port bundle between the March engine and a macro
// Revision: 1.0
// =============================================================================
interface sram_march_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) ();
    logic              bist_en_o;
    logic              bist_men_o;
    logic              bist_wen_o;
    logic              bist_ren_o;
    logic [ADDR_W-1:0] bist_addr_o;
    logic [DATA_W-1:0] bist_din_o;
    logic [DATA_W-1:0] bist_bm_o;
    logic [DATA_W-1:0] sram_dout_i;

    modport master (
        output bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
        output bist_addr_o, bist_din_o, bist_bm_o,
        input  sram_dout_i
    );

    modport slave (
        input  bist_en_o, bist_men_o, bist_wen_o, bist_ren_o,
        input  bist_addr_o, bist_din_o, bist_bm_o,
        output sram_dout_i
    );
endinterface
`default_nettype wire

// File: rtl/sram_march_bist.sv
`default_nettype none
// =============================================================================
// sram_march_bist : March C- memory BIST engine with registered SRAM port/status
// Revision: 1.0
// =============================================================================
module sram_march_bist #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    sram_march_bist_if.master bist
);
    typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] c_ADDR_TOP = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_wr_ph, w_wr_ph_nxt;
    logic              w_down, w_last, w_start_ok;
    logic              w_acc, w_wr, w_bg, w_busy_nxt;

    logic              r_busy, r_done, r_men, r_wen, r_ren, r_rd_bg;
    logic [ADDR_W-1:0] r_baddr;
    logic [DATA_W-1:0] r_din, r_bm;
    logic              r_pend_vld, r_pend_bg;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [CNT_W-1:0]  r_fail_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wr_ph <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wr_ph <= w_wr_ph_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wr_ph_nxt = r_wr_ph;
        w_start_ok  = 1'b0;
        w_down      = (r_state == M3) || (r_state == M4) || (r_state == M5);
        w_last      = w_down ? (r_addr == '0) : (r_addr == c_ADDR_TOP);
        case (r_state)
            IDLE, DONE: begin
                if (start_i) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = M0;
                    w_addr_nxt  = '0;
                    w_wr_ph_nxt = 1'b0;
                end
            end
            M0: begin
                if (w_last) begin
                    w_state_nxt = M1;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + c_ADDR_ONE;
                end
            end
            M1, M2, M3, M4: begin
                // Read phase then write phase at the same address; step after the write.
                if (!r_wr_ph) begin
                    w_wr_ph_nxt = 1'b1;
                end else begin
                    w_wr_ph_nxt = 1'b0;
                    if (!w_last) begin
                        w_addr_nxt = w_down ? (r_addr - c_ADDR_ONE) : (r_addr + c_ADDR_ONE);
                    end else begin
                        case (r_state)
                            M1:      begin w_state_nxt = M2; w_addr_nxt = '0;         end
                            M2:      begin w_state_nxt = M3; w_addr_nxt = c_ADDR_TOP; end
                            M3:      begin w_state_nxt = M4; w_addr_nxt = c_ADDR_TOP; end
                            default: begin w_state_nxt = M5; w_addr_nxt = c_ADDR_TOP; end
                        endcase
                    end
                end
            end
            M5: begin
                if (w_last) w_state_nxt = FLUSH;
                else        w_addr_nxt  = r_addr - c_ADDR_ONE;
            end
            FLUSH:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase

        // Decode the access of the upcoming cycle so the port is driven from flops.
        w_acc = 1'b0;
        w_wr  = 1'b0;
        w_bg  = 1'b0;
        case (w_state_nxt)
            M0:      begin w_acc = 1'b1; w_wr = 1'b1; end
            M1, M3:  begin w_acc = 1'b1; w_wr = w_wr_ph_nxt; w_bg = w_wr_ph_nxt;  end
            M2, M4:  begin w_acc = 1'b1; w_wr = w_wr_ph_nxt; w_bg = ~w_wr_ph_nxt; end
            M5:      w_acc = 1'b1;
            default: ;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_men       <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_rd_bg     <= 1'b0;
            r_baddr     <= '0;
            r_din       <= '0;
            r_bm        <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_bg   <= 1'b0;
            r_pend_addr <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_done      <= (w_state_nxt == DONE);
            r_men       <= w_acc;
            r_wen       <= w_acc & w_wr;
            r_ren       <= w_acc & ~w_wr;
            r_rd_bg     <= w_bg;
            r_baddr     <= w_acc ? w_addr_nxt : '0;
            r_din       <= (w_acc && w_wr) ? {DATA_W{w_bg}} : '0;
            r_bm        <= w_acc ? '1 : '0;
            // Read data returns one cycle after the read, so expectation lags by one.
            r_pend_vld  <= r_ren;
            r_pend_bg   <= r_rd_bg;
            r_pend_addr <= r_baddr;
            if (w_start_ok) begin
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_cnt  <= '0;
            end else if (r_pend_vld && (bist.sram_dout_i != {DATA_W{r_pend_bg}})) begin
                r_fail <= 1'b1;
                if (!r_fail) r_fail_addr <= r_pend_addr;
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + c_CNT_ONE;
            end
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign fail_o           = r_fail;
    assign fail_addr_o      = r_fail_addr;
    assign fail_cnt_o       = r_fail_cnt;
    assign bist.bist_en_o   = r_busy;
    assign bist.bist_men_o  = r_men;
    assign bist.bist_wen_o  = r_wen;
    assign bist.bist_ren_o  = r_ren;
    assign bist.bist_addr_o = r_baddr;
    assign bist.bist_din_o  = r_din;
    assign bist.bist_bm_o   = r_bm;
endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`default_nettype none
// =============================================================================
// tb_sram_march_bist : self-checking bench with SRAM fault model and March C- reference
// Revision: 1.0
// =============================================================================
module tb_sram_march_bist;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 64;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int RUN_CYC = 10 * DEPTH + 1;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic              bg;
    } op_t;

    logic              clk_i   = 1'b0;
    logic              rst_ni  = 1'b0;
    logic              start_i = 1'b0;
    logic              busy_o, done_o, fail_o;
    logic [ADDR_W-1:0] fail_addr_o;
    logic [CNT_W-1:0]  fail_cnt_o;

    sram_march_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_cnt_o  (fail_cnt_o),
        .bist        (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sa1 [DEPTH];
    logic [DATA_W-1:0] sa0 [DEPTH];
    op_t               exp_q [$];
    logic              exp_fail;
    logic [ADDR_W-1:0] exp_faddr;
    int                exp_fcnt;
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic t_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM with stuck-at faults applied on the read path.
    always @(posedge clk_i) begin
        if (bus.bist_men_o && bus.bist_wen_o)
            mem[bus.bist_addr_o] <= (bus.bist_din_o & bus.bist_bm_o) | (mem[bus.bist_addr_o] & ~bus.bist_bm_o);
        if (bus.bist_men_o && bus.bist_ren_o)
            bus.sram_dout_i <= (mem[bus.bist_addr_o] | sa1[bus.bist_addr_o]) & ~sa0[bus.bist_addr_o];
    end

    // Port monitor: every access must match the next operation of the reference sequence.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.bist_men_o) begin
                if (exp_q.size() == 0) begin
                    t_check("acc_unexpected", 64'(bus.bist_men_o), 64'd0);
                end else begin
                    op_t op;
                    op = exp_q.pop_front();
                    t_check("acc_op", 64'({bus.bist_wen_o, bus.bist_ren_o, bus.bist_addr_o}),
                            64'({op.wr, ~op.wr, op.addr}));
                    t_check("acc_din", bus.bist_din_o, op.wr ? {DATA_W{op.bg}} : 64'd0);
                    t_check("acc_bm", bus.bist_bm_o, {DATA_W{1'b1}});
                end
            end else begin
                t_check("idle_ctl", 64'({bus.bist_wen_o, bus.bist_ren_o, bus.bist_addr_o}), 64'd0);
                t_check("idle_din", bus.bist_din_o, 64'd0);
            end
        end
    end

    // Reference: enumerate March C- from its element table and evaluate faults on a model array.
    task automatic build_run();
        logic [DATA_W-1:0] mm [DEPTH];
        logic [DATA_W-1:0] v;
        op_t op;
        int  a;
        bit  up, has_rd, has_wr, rd_bg, wr_bg;
        exp_fail  = 1'b0;
        exp_faddr = '0;
        exp_fcnt  = 0;
        for (int e = 0; e < 6; e++) begin
            up     = (e < 3);
            has_rd = (e != 0);
            has_wr = (e != 5);
            rd_bg  = (e == 2) || (e == 4);
            wr_bg  = (e == 1) || (e == 3);
            for (int i = 0; i < DEPTH; i++) begin
                a = up ? i : DEPTH - 1 - i;
                if (has_rd) begin
                    op.wr = 1'b0; op.addr = ADDR_W'(a); op.bg = rd_bg;
                    exp_q.push_back(op);
                    v = (mm[a] | sa1[a]) & ~sa0[a];
                    if (v !== {DATA_W{rd_bg}}) begin
                        if (!exp_fail) exp_faddr = ADDR_W'(a);
                        exp_fail = 1'b1;
                        exp_fcnt++;
                    end
                end
                if (has_wr) begin
                    op.wr = 1'b1; op.addr = ADDR_W'(a); op.bg = wr_bg;
                    exp_q.push_back(op);
                    mm[a] = {DATA_W{wr_bg}};
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    task automatic add_fault(input int a, input int b, input bit val);
        if (val) sa1[a][b] = 1'b1;
        else     sa0[a][b] = 1'b1;
    endtask

    task automatic wait_run(input string tag, input int cyc0);
        int cyc;
        cyc = cyc0;
        while (busy_o && cyc < 5 * RUN_CYC) begin
            cyc++;
            @(negedge clk_i);
        end
        t_check({tag, "_busy_cyc"}, 64'(cyc), 64'(RUN_CYC));
        t_check({tag, "_done"}, 64'(done_o), 64'd1);
        t_check({tag, "_fail"}, 64'(fail_o), 64'(exp_fail));
        t_check({tag, "_faddr"}, 64'(fail_addr_o), 64'(exp_faddr));
        t_check({tag, "_fcnt"}, 64'(fail_cnt_o), 64'(exp_fcnt));
        t_check({tag, "_q_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_check(input string tag);
        build_run();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_run(tag, 0);
    endtask

    initial begin
        int a1, a2;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        clear_faults();

        repeat (3) @(negedge clk_i);
        t_check("rst_status", 64'({busy_o, done_o, fail_o, fail_addr_o, fail_cnt_o}), 64'd0);
        t_check("rst_bus_ctl", 64'({bus.bist_en_o, bus.bist_men_o, bus.bist_wen_o,
                                    bus.bist_ren_o, bus.bist_addr_o}), 64'd0);
        t_check("rst_din", bus.bist_din_o, 64'd0);
        t_check("rst_bm", bus.bist_bm_o, 64'd0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        t_check("idle_wait", 64'({busy_o, done_o, bus.bist_en_o}), 64'd0);

        run_check("clean");

        clear_faults();
        add_fault(8'h5A, 3, 1'b1);
        run_check("sa1_5a");
        t_check("sa1_5a_cnt3", 64'(fail_cnt_o), 64'd3);
        t_check("sa1_5a_addr", 64'(fail_addr_o), 64'h5A);

        for (int r = 0; r < 3; r++) begin
            clear_faults();
            add_fault($urandom_range(DEPTH - 1, 0), $urandom_range(DATA_W - 1, 0), 1'($urandom));
            run_check($sformatf("rnd%0d", r));
        end

        clear_faults();
        a1 = $urandom_range(DEPTH - 1, 0);
        a2 = (a1 + 1 + $urandom_range(DEPTH - 2, 0)) % DEPTH;
        add_fault(a1, $urandom_range(DATA_W - 1, 0), 1'b0);
        add_fault(a2, $urandom_range(DATA_W - 1, 0), 1'b1);
        run_check("two_flt");

        // start_i held high: one full run, then an immediate second run clearing status.
        clear_faults();
        add_fault($urandom_range(DEPTH - 1, 0), $urandom_range(DATA_W - 1, 0), 1'b1);
        build_run();
        build_run();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        begin
            int cyc;
            cyc = 0;
            while (busy_o && cyc < 5 * RUN_CYC) begin
                cyc++;
                @(negedge clk_i);
            end
            t_check("hold1_busy_cyc", 64'(cyc), 64'(RUN_CYC));
            t_check("hold1_done", 64'(done_o), 64'd1);
            t_check("hold1_fcnt", 64'(fail_cnt_o), 64'(exp_fcnt));
        end
        @(negedge clk_i);
        start_i = 1'b0;
        t_check("hold2_restart", 64'({busy_o, done_o, fail_o, fail_addr_o, fail_cnt_o}),
                64'({1'b1, 1'b0, 1'b0, {ADDR_W{1'b0}}, {CNT_W{1'b0}}}));
        wait_run("hold2", 0);

        // Asynchronous reset at cycle 700 of a run.
        clear_faults();
        build_run();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (699) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        t_check("arst_status", 64'({busy_o, done_o, fail_o, fail_addr_o, fail_cnt_o}), 64'd0);
        t_check("arst_bus_ctl", 64'({bus.bist_en_o, bus.bist_men_o, bus.bist_wen_o,
                                     bus.bist_ren_o, bus.bist_addr_o}), 64'd0);
        t_check("arst_din_bm", bus.bist_din_o | bus.bist_bm_o, 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        t_check("arst_after", 64'({busy_o, done_o, fail_o, fail_cnt_o}), 64'd0);

        clear_faults();
        add_fault($urandom_range(DEPTH - 1, 0), $urandom_range(DATA_W - 1, 0), 1'b0);
        run_check("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001: Parameter ADDR_W, default 8, SRAM address width; depth = 2**ADDR_W.
REQ-002: Parameter DATA_W, default 64, SRAM data and bit-mask width.
REQ-003: Parameter CNT_W, default 16, width of the failure counter.
REQ-004: Port clk_i, input, 1, sole clock; it also drives the SRAM BIST clock pin.
REQ-005: Port rst_ni, input, 1, asynchronous active-low reset.
REQ-006: Port start_i, input, 1, single-cycle request to begin a test run.
REQ-007: Port busy_o, output, 1, high while a run is in progress.
REQ-008: Port done_o, output, 1, high from run completion until the next accepted start.
REQ-009: Port fail_o, output, 1, sticky mismatch flag for the last run.
REQ-010: Port fail_addr_o, output, ADDR_W, address of the first mismatching read.
REQ-011: Port fail_cnt_o, output, CNT_W, number of mismatching reads; saturates at all-ones.
REQ-012: Ports bist_en_o, bist_men_o, bist_wen_o and bist_ren_o, outputs, 1 each; they drive the SRAM BIST select, macro enable, write enable and read enable.
REQ-013: Ports bist_addr_o (ADDR_W), bist_din_o (DATA_W) and bist_bm_o (DATA_W), outputs; they drive the SRAM BIST address, data and bit mask.
REQ-014: Port sram_dout_i, input, DATA_W, SRAM read data, valid on the cycle after a read access.

Function
REQ-015: The block SHALL run March C- with background 0 = all-zeros and background 1 = all-ones.
REQ-016: The elements SHALL run in order: M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 down r0.
REQ-017: FSM states SHALL be IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE.
REQ-018: "up" SHALL mean address 0 to depth-1; "down" SHALL mean address depth-1 to 0.
REQ-019: M0 and M5 SHALL issue one access per cycle.
REQ-020: M1 to M4 SHALL issue, per address, a read cycle followed by a write cycle to the same address.
REQ-021: Element exit SHALL occur on the terminal address (depth-1 for up, 0 for down) after that address's last operation, with no idle cycle between elements.
REQ-022: The address counter SHALL be loaded, on entry to each element, with 0 for up elements and depth-1 for down elements.
REQ-023: In IDLE or DONE, a start_i sampled high SHALL move the FSM to M0 and clear fail_o, fail_addr_o, fail_cnt_o and done_o on the same edge.
REQ-024: start_i SHALL be ignored in states M0 to FLUSH.
REQ-025: The first write SHALL be issued in the cycle after start_i is sampled.
REQ-026: During an access cycle, bist_men_o SHALL be 1, with exactly one of bist_wen_o and bist_ren_o equal to 1.
REQ-027: During an access cycle, bist_bm_o SHALL be all-ones and bist_din_o SHALL be the background value being written.
REQ-028: bist_en_o and busy_o SHALL be 1 in states M0 to FLUSH and 0 otherwise.
REQ-029: Outside access cycles, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o and bist_din_o SHALL be 0.
REQ-030: Each read SHALL register an expected value and its address, and sram_dout_i SHALL be compared against that expected value in the following cycle.
REQ-031: On the first mismatch of a run, fail_addr_o SHALL capture the read address.
REQ-032: Every mismatch SHALL set fail_o and increment fail_cnt_o, holding fail_cnt_o at its maximum value.
REQ-033: FLUSH SHALL last exactly one cycle, compare the final M5 read, and then enter DONE.
REQ-034: Entering DONE SHALL set done_o.
REQ-035: A full run SHALL take 10*depth access cycles plus 1 FLUSH cycle; for depth 256 that is 2561 cycles from the start_i edge to done_o high.
REQ-036: All outputs SHALL be registered.

Reset
REQ-037: An asynchronous assertion of rst_ni SHALL force IDLE.
REQ-038: An asynchronous assertion of rst_ni SHALL clear every output to 0, including the status outputs and the address counter.
REQ-039: A reset asserted mid-run SHALL abort the run immediately, leaving no pending compare, with done_o=0 after release.
REQ-040: After rst_ni deasserts, the block SHALL stay in IDLE until start_i is sampled high.

Verification
REQ-041: Fault-free SRAM model, depth 256, pulse start_i -> busy_o high for 2561 cycles; done_o=1, fail_o=0, fail_cnt_o=0.
REQ-042: Model bit 3 stuck-at-1 at address 0x5A, then run -> fail_o=1, fail_addr_o=0x5A, fail_cnt_o=3 (failing reads: M2 r1 is good; M1 r0, M3 r0 and M5 r0 fail).
REQ-043: Hold start_i high throughout a run -> exactly one run; DONE is followed immediately by a second run that clears the status.
REQ-044: Assert rst_ni low at cycle 700 of a run -> all outputs 0 asynchronously; after release busy_o=0 and done_o=0, and a fresh start completes normally.
REQ-045: Bus-protocol checker for the whole run -> wen and ren are never both 1, bm is always all-ones, and the address sequence matches REQ-016 to REQ-022 (M3 begins at 0xFF immediately after M2 ends at 0xFF).
